branch_redirect_ctrl: RTL
=========================

# branch_redirect_ctrl

Branch-resolution controller behind the EXE-up stages of both issue lanes. It takes per-lane branch resolution results (mispredict flag, corrected target, checkpoint, repair action) and picks the oldest mispredicting branch. It then issues a one-cycle pipeline flush and holds a redirect request toward fetch/BPU repair until it is accepted. It also keeps wrap-around prediction statistics counters.

## Interface
- VADDR_W, 32, virtual address width
- CKPT_W, 8, checkpoint field width (`ALL_CHECKPOINT`)
- REPAIR_W, 4, repair-action field width (`REPAIR_ACTION`); MSB = need-repair
- CNT_W, 32, statistics counter width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- br_valid_i  in  2  lane result valid this cycle (lane0 older than lane1)
- br_isBranch_i  in  2  lane holds a branch/jump
- br_risk_i  in  2  lane mispredicted (needs repair)
- br_corrTake_i  in  2  resolved taken
- br_corrDest_i  in  2*VADDR_W  resolved next PC, lane0 in [VADDR_W-1:0]
- br_checkPoint_i  in  2*CKPT_W  per-lane checkpoint
- br_repairAction_i  in  2*REPAIR_W  per-lane repair action
- exc_flush_i  in  1  CP0 exception/eret flush, highest priority
- redirect_ready_i  in  1  fetch/BPU accepts redirect
- flush_o  out  1  one-cycle flush pulse to younger stages
- redirect_valid_o  out  1  redirect request pending
- redirect_lane_o  out  1  lane of selected branch (consumer keeps its delay slot)
- redirect_pc_o  out  VADDR_W  redirect target
- redirect_take_o  out  1  resolved direction
- redirect_checkPoint_o  out  CKPT_W  checkpoint to restore
- redirect_repairAction_o  out  REPAIR_W  repair action
- busy_o  out  1  controller not IDLE; ID must stall issue
- hit_cnt_o, miss_cnt_o  out  CNT_W  correct / mispredicted branches
- takenHit_cnt_o  out  CNT_W  correct predictions that were taken

## Operation
- States: IDLE, REDIRECT.
- A lane is live when br_valid_i[i] & br_isBranch_i[i].
- A lane is a miss when it is live & br_risk_i[i].
- Selection in IDLE: lane0 miss wins; otherwise lane1 miss.
- When lane0 is the winner, lane1 results are discarded, including for statistics.
- IDLE → REDIRECT when a miss exists and exc_flush_i=0. The selected lane's fields are captured into the redirect_* registers.
- REDIRECT:
  - All br_* inputs are ignored, since those instructions are younger and being squashed.
  - redirect_* outputs stay stable until redirect_valid_o & redirect_ready_i.
  - On that handshake, next state is IDLE.
- exc_flush_i=1 in any state: next state is IDLE, redirect_valid_o drops next cycle, no flush_o is generated, no counters update. This also holds for a miss or handshake in the same cycle.
- Counters, evaluated only in IDLE with exc_flush_i=0:
  - Per counted live lane: hit_cnt +1 if not risk, else miss_cnt +1.
  - takenHit_cnt +1 if not risk & corrTake.
  - Both lanes may add in one cycle (+2).
  - Counters wrap modulo 2^CNT_W.
- busy_o = (state==REDIRECT).

## Timing
- Reset (rst=0 at a clk edge) gives:
  - state IDLE;
  - flush_o=0, redirect_valid_o=0, redirect_lane_o=0, redirect_pc_o=0, redirect_take_o=0;
  - checkpoint and repair outputs 0;
  - all counters 0.
- Reset mid-REDIRECT abandons the request.
- Miss detected in cycle N gives, in cycle N+1, flush_o=1 (exactly one cycle) and redirect_valid_o=1. Latency 1.
- Handshake in cycle M gives redirect_valid_o=0 and state IDLE in M+1. A new miss can be accepted in M+1, so back-to-back redirects are spaced ≥2 cycles.
- redirect_ready_i high in N+1 means the request lasts exactly one cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive rst=0 for 2 cycles with random inputs → all outputs 0, busy_o=0.
- Lane1-only miss, corrDest=0xBFC0_0100, ckpt=0x5A, ready=1 → cycle N+1: flush_o=1, redirect_valid_o=1, redirect_lane_o=1, pc=0xBFC0_0100; N+2: valid=0, busy=0; miss_cnt=1.
- Both lanes miss (lane0 dest 0x1000, lane1 dest 0x2000) → redirect_pc_o=0x1000, lane=0, miss_cnt=1, hit_cnt=0.
- Miss with ready held 0 for 5 cycles while lanes keep reporting misses → flush_o high only once, outputs stable, counters frozen; handshake on cycle 6 gives IDLE next cycle.
- exc_flush_i asserted in REDIRECT, and separately together with a lane0 miss in IDLE → valid=0 next cycle, no flush_o, counters unchanged.
- Two correct taken branches per cycle for 4 cycles, starting from hit_cnt preloaded near wrap via CNT_W=3 → hit_cnt 0→2→4→6→0, takenHit_cnt same.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Picks the oldest mispredicting branch across two issue lanes, pulses a flush,
// holds a redirect toward fetch/BPU until accepted, and keeps prediction counters.
module branch_redirect_ctrl #(
    parameter int VADDR_W  = 32,
    parameter int CKPT_W   = 8,
    parameter int REPAIR_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            br_valid_i,
    input  logic [1:0]            br_isBranch_i,
    input  logic [1:0]            br_risk_i,
    input  logic [1:0]            br_corrTake_i,
    input  logic [2*VADDR_W-1:0]  br_corrDest_i,
    input  logic [2*CKPT_W-1:0]   br_checkPoint_i,
    input  logic [2*REPAIR_W-1:0] br_repairAction_i,
    input  logic                  exc_flush_i,
    input  logic                  redirect_ready_i,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    output logic                  redirect_lane_o,
    output logic [VADDR_W-1:0]    redirect_pc_o,
    output logic                  redirect_take_o,
    output logic [CKPT_W-1:0]     redirect_checkPoint_o,
    output logic [REPAIR_W-1:0]   redirect_repairAction_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      hit_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o,
    output logic [CNT_W-1:0]      takenHit_cnt_o
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t              state_q;
    logic                flush_q;
    logic                lane_q;
    logic [VADDR_W-1:0]  pc_q;
    logic                take_q;
    logic [CKPT_W-1:0]   ckpt_q;
    logic [REPAIR_W-1:0] repair_q;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    takenHit_cnt_q, takenHit_cnt_d;

    logic [1:0]          live, miss, counted, hit_inc, miss_inc, taken_inc;
    logic                sel;
    logic [VADDR_W-1:0]  sel_pc;
    logic                sel_take;
    logic [CKPT_W-1:0]   sel_ckpt;
    logic [REPAIR_W-1:0] sel_repair;

    always_comb begin
        live      = br_valid_i & br_isBranch_i;
        miss      = live & br_risk_i;
        sel       = ~miss[0];
        // A lane0 miss squashes lane1 entirely, so lane1 must not be counted.
        counted   = {live[1] & ~miss[0], live[0]};
        hit_inc   = counted & ~br_risk_i;
        miss_inc  = counted & br_risk_i;
        taken_inc = hit_inc & br_corrTake_i;

        hit_cnt_d      = hit_cnt_q + CNT_W'(hit_inc[0]) + CNT_W'(hit_inc[1]);
        miss_cnt_d     = miss_cnt_q + CNT_W'(miss_inc[0]) + CNT_W'(miss_inc[1]);
        takenHit_cnt_d = takenHit_cnt_q + CNT_W'(taken_inc[0]) + CNT_W'(taken_inc[1]);

        sel_pc     = sel ? br_corrDest_i[2*VADDR_W-1:VADDR_W]      : br_corrDest_i[VADDR_W-1:0];
        sel_take   = sel ? br_corrTake_i[1]                         : br_corrTake_i[0];
        sel_ckpt   = sel ? br_checkPoint_i[2*CKPT_W-1:CKPT_W]       : br_checkPoint_i[CKPT_W-1:0];
        sel_repair = sel ? br_repairAction_i[2*REPAIR_W-1:REPAIR_W] : br_repairAction_i[REPAIR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            flush_q        <= 1'b0;
            lane_q         <= 1'b0;
            pc_q           <= '0;
            take_q         <= 1'b0;
            ckpt_q         <= '0;
            repair_q       <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            takenHit_cnt_q <= '0;
        end else begin
            flush_q <= 1'b0;
            if (exc_flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        hit_cnt_q      <= hit_cnt_d;
                        miss_cnt_q     <= miss_cnt_d;
                        takenHit_cnt_q <= takenHit_cnt_d;
                        if (|miss) begin
                            state_q  <= REDIRECT;
                            flush_q  <= 1'b1;
                            lane_q   <= sel;
                            pc_q     <= sel_pc;
                            take_q   <= sel_take;
                            ckpt_q   <= sel_ckpt;
                            repair_q <= sel_repair;
                        end
                    end
                    REDIRECT: begin
                        // Younger lane results are being squashed; only the handshake matters.
                        if (redirect_ready_i) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign flush_o                 = flush_q;
    assign redirect_valid_o        = (state_q == REDIRECT);
    assign busy_o                  = (state_q == REDIRECT);
    assign redirect_lane_o         = lane_q;
    assign redirect_pc_o           = pc_q;
    assign redirect_take_o         = take_q;
    assign redirect_checkPoint_o   = ckpt_q;
    assign redirect_repairAction_o = repair_q;
    assign hit_cnt_o               = hit_cnt_q;
    assign miss_cnt_o              = miss_cnt_q;
    assign takenHit_cnt_o          = takenHit_cnt_q;

endmodule
